// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed little-endian byte stream into
// instruction-memory words and holds the core in reset until the image is complete.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned LEN_W = 16;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0, S_LEN_HI = 3'd1, S_DATA = 3'd2, S_FLUSH = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5, S_CSUM = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0, S_LEN_HI = 3'd1, S_DATA = 3'd2, S_FLUSH = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5
  } state_e;
`endif

  state_e              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_reset_n_q, core_reset_n_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;
  logic [LEN_W-1:0]    n_c;
  logic                xfer_c;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign xfer_c = rx_valid && rx_ready_q;
  assign n_c    = {rx_data, len_lo_q};

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    if (xfer_c) csum_d = csum_q ^ rx_data;
`endif

    unique case (state_q)
      S_LEN_LO: begin
        if (xfer_c) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d = n_c;
          if (n_c == '0 || 32'(n_c) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            idx_d      = '0;
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          if (byte_cnt_q == 2'd3) begin
            imem_wdata_d = {rx_data, word_q};
            imem_addr_d  = ADDR_W'(idx_q);
            imem_we_d    = 1'b1;
            byte_cnt_d   = '0;
            if (idx_q == LEN_W'(len_q - LEN_W'(1))) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FLUSH;
`endif
            end else begin
              idx_d = LEN_W'(idx_q + LEN_W'(1));
            end
          end else begin
            unique case (byte_cnt_q)
              2'd0:    word_d[7:0]   = rx_data;
              2'd1:    word_d[15:8]  = rx_data;
              default: word_d[23:16] = rx_data;
            endcase
            byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_c) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d    = S_LEN_LO;
          len_lo_d   = '0;
          len_d      = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
          word_d     = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      default: state_d = S_LEN_LO;
    endcase

    // Status outputs follow the upcoming state so they are valid in that state's first cycle
    rx_ready_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                     || (state_d == S_CSUM)
`endif
                     ;
    core_reset_n_d = (state_d == S_DONE);
    load_done_d    = (state_d == S_DONE);
    load_err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_LEN_LO;
      rx_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      len_lo_q       <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_reset_n_q <= core_reset_n_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
      len_lo_q       <= len_lo_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset_n = core_reset_n_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-level reference model.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1024;

  typedef logic [7:0]        byte_t;
  typedef logic [ADDR_W+31:0] wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset_n;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int errors = 0;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write/release monitor sampled on the falling edge
  wr_t  got_q[$];
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   rel_cyc = 0;
  int   viol = 0;
  logic crn_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) begin
      got_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
    if (core_reset_n === 1'b1 && imem_we === 1'b1) viol++;
    if (core_reset_n === 1'b1 && crn_prev !== 1'b1) rel_cyc = cyc;
    crn_prev = core_reset_n;
  end

  function automatic void add_csum(inout byte_t s[$]);
`ifdef PROG_LOADER_CHECKSUM_EN
    byte_t x;
    x = 8'h00;
    foreach (s[k]) x ^= s[k];
    s.push_back(x);
`endif
  endfunction

  function automatic void make_image(input int n, output byte_t s[$]);
    s = {};
    s.push_back(byte_t'(n));
    s.push_back(byte_t'(n >> 8));
    for (int i = 0; i < 4 * n; i++) s.push_back(byte_t'($urandom));
    add_csum(s);
  endfunction

  // Reference: decode the stream by its format rules into expected writes and outcome
  task automatic model(input byte_t s[$], output wr_t exp[$], output bit exp_err);
    int n;
    exp = {};
    n = int'(s[0]) + 256 * int'(s[1]);
    exp_err = (n == 0) || (n > int'(MAX_WORDS));
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
        exp.push_back({ADDR_W'(i), w});
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      begin
        byte_t x;
        x = 8'h00;
        for (int k = 0; k < 2 + 4 * n; k++) x ^= s[k];
        exp_err = (s[2+4*n] != x);
      end
`endif
    end
  endtask

  task automatic send_stream(input byte_t s[$], input int max_gap);
    int budget;
    foreach (s[i]) begin
      if (max_gap > 0) begin
        int g;
        g = int'($urandom_range(max_gap, 0));
        repeat (g) begin @(negedge clk); rx_valid = 1'b0; end
      end
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
      budget   = 0;
      while (rx_ready !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
      if (budget >= 50) begin
        checks++; errors++;
        $display("FAIL send_timeout byte %0d rx_ready=%b want 1", i, rx_ready);
        break;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    int b;
    b = 0;
    while (load_done !== 1'b1 && load_err !== 1'b1 && b < 300) begin @(negedge clk); b++; end
    timed_out = (b >= 300);
    #1;
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    got_q = {};
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, load_done, load_err});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL ready_first_cycle got %b want 0", rx_ready); end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", rx_ready); end
  endtask

  task automatic test_back_to_back();
    byte_t s[$];
    bit to;
    got_q = {};
    s = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    add_csum(s);
    send_stream(s, 0);
    wait_end(to);
    checks++;
    if (to || load_done !== 1'b1 || core_reset_n !== 1'b1) begin
      errors++; $display("FAIL b2b_done got done=%b crn=%b to=%b want 1 1 0", load_done, core_reset_n, to);
    end
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {10'd0, 32'h00A00513}) begin errors++; $display("FAIL b2b_w0 got %h want %h", got_q[0], {10'd0, 32'h00A00513}); end
      checks++;
      if (got_q[1] !== {10'd1, 32'h00100593}) begin errors++; $display("FAIL b2b_w1 got %h want %h", got_q[1], {10'd1, 32'h00100593}); end
    end
    checks++;
    if (rel_cyc != last_we_cyc + 1) begin
      errors++; $display("FAIL b2b_release got cycle %0d want %0d", rel_cyc, last_we_cyc + 1);
    end
  endtask

  task automatic test_gaps();
    byte_t s[$];
    wr_t exp[$];
    bit ee, to;
    do_restart();
    s = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    add_csum(s);
    model(s, exp, ee);
    send_stream(s, 5);
    wait_end(to);
    checks++;
    if (to || load_done !== !ee || load_err !== ee) begin
      errors++; $display("FAIL gaps_end got done=%b err=%b want err=%b", load_done, load_err, ee);
    end
    checks++;
    if (got_q.size() != exp.size()) begin
      errors++; $display("FAIL gaps_count got %0d want %0d", got_q.size(), exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL gaps_w%0d got %h want %h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (rel_cyc <= last_we_cyc) begin errors++; $display("FAIL gaps_release got %0d want > %0d", rel_cyc, last_we_cyc); end
  endtask

  task automatic test_len_err();
    byte_t s[$];
    bit to;
    for (int k = 0; k < 2; k++) begin
      do_restart();
      s = (k == 0) ? '{8'h00, 8'h00} : '{8'h01, 8'h04};
      send_stream(s, 2);
      wait_end(to);
      repeat (3) @(negedge clk);
      checks++;
      if (to || load_err !== 1'b1 || load_done !== 1'b0 || core_reset_n !== 1'b0 || got_q.size() != 0) begin
        errors++;
        $display("FAIL len_err_%0d got err=%b done=%b crn=%b writes=%0d want 1 0 0 0",
                 k, load_err, load_done, core_reset_n, got_q.size());
      end
    end
    do_restart();
    make_image(1, s);
    send_stream(s, 1);
    wait_end(to);
    checks++;
    if (to || load_done !== 1'b1 || load_err !== 1'b0 || got_q.size() != 1) begin
      errors++; $display("FAIL len_err_recover got done=%b err=%b writes=%0d want 1 0 1", load_done, load_err, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    byte_t s[$], part[$];
    wr_t exp[$];
    bit ee, to;
    do_restart();
    make_image(3, s);
    part = s[0:6];
    send_stream(part, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, load_done, load_err});
    end
    @(negedge clk);
    reset = 1'b1;
    got_q = {};
    make_image(3, s);
    model(s, exp, ee);
    send_stream(s, 2);
    wait_end(to);
    checks++;
    if (to || load_done !== !ee || got_q.size() != exp.size()) begin
      errors++; $display("FAIL reset_mid_reload got done=%b writes=%0d want %b %0d", load_done, got_q.size(), !ee, exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL reset_mid_w%0d got %h want %h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_restart();
    byte_t s[$];
    wr_t exp[$];
    bit ee, to;
    do_restart();
    checks++;
    if (core_reset_n !== 1'b0 || load_done !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL restart_exit got crn=%b done=%b rdy=%b want 0 0 1", core_reset_n, load_done, rx_ready);
    end
    make_image(1, s);
    model(s, exp, ee);
    send_stream(s, 0);
    wait_end(to);
    checks++;
    if (to || load_done !== 1'b1 || got_q.size() != 1 || got_q[0] !== exp[0]) begin
      errors++; $display("FAIL restart_overwrite got done=%b writes=%0d w=%h want 1 1 %h",
                         load_done, got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp[0]);
    end
  endtask

  task automatic test_random();
    byte_t s[$];
    wr_t exp[$];
    bit ee, to;
    for (int it = 0; it < 8; it++) begin
      do_restart();
      make_image(int'($urandom_range(8, 1)), s);
`ifdef PROG_LOADER_CHECKSUM_EN
      if ($urandom_range(1, 0) == 1) s[s.size()-1] ^= 8'h5A;
`endif
      model(s, exp, ee);
      send_stream(s, int'($urandom_range(3, 0)));
      wait_end(to);
      repeat (2) @(negedge clk);
      checks++;
      if (to || load_done !== !ee || load_err !== ee || core_reset_n !== !ee) begin
        errors++; $display("FAIL rand%0d_end got done=%b err=%b crn=%b want err=%b", it, load_done, load_err, core_reset_n, ee);
      end
      checks++;
      if (got_q.size() != exp.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), exp.size());
      end else foreach (exp[i]) begin
        checks++;
        if (got_q[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_w%0d got %h want %h", it, i, got_q[i], exp[i]); end
      end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_t s[$];
    bit to;
    for (int k = 0; k < 2; k++) begin
      do_restart();
      s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      s.push_back((k == 0) ? 8'h23 : 8'h24);
      send_stream(s, 0);
      wait_end(to);
      checks++;
      if (to || load_done !== (k == 0) || load_err !== (k == 1) || core_reset_n !== (k == 0)) begin
        errors++; $display("FAIL csum_%0d got done=%b err=%b crn=%b", k, load_done, load_err, core_reset_n);
      end
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {10'd0, 32'hDEADBEEF}) begin
        errors++; $display("FAIL csum_%0d_write got n=%0d want 1 word DEADBEEF", k, got_q.size());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_err();
    test_reset_mid();
    test_restart();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (viol != 0) begin errors++; $display("FAIL release_during_write got %0d want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
